// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, parity-mode constants and bit-period helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int calc_cpb(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop rx synchronizer with optional 2-of-3 majority sample filter
// ports: clk, rst (async active-low), rx (raw line), rx_s (synchronized line), sample_bit (value to sample)
// build option: UART_RX_MAJORITY_EN makes sample_bit the majority of the last three rx_s values
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic sample_bit
);
  logic meta;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      hist <= 2'b11;
    end else begin
      meta <= rx;
      rx_s <= meta;
      hist <= {hist[0], rx_s};
    end
  // window covers the line at bit offsets CPB/2-2..CPB/2 when sampled at the decision point
  assign sample_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  assign sample_bit = rx_s;
`endif
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with valid/ready output and parity/framing/overrun status
// ports: clk, rst (async active-low), rx (serial line), data_out/data_valid/data_ready (frame handshake),
//        parity_err/frame_err/overrun (status of presented frame), busy (frame in progress)
// build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling inside uart_rx_sync
module uart_rx_param import uart_pkg::*; #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CPB = calc_cpb(CLK_FREQ, BAUD_RATE);
  localparam int TW  = $clog2(CPB);
  localparam int IW  = $clog2(DATA_BITS);
  rx_state_t state, next;
  logic rx_s, rx_prev, sample_bit, tick_half, tick_full, done, stop_idx, perr, ferr;
  logic [TW-1:0] timer;
  logic [IW-1:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  uart_rx_sync u_sync (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_s(rx_s),
    .sample_bit(sample_bit)
  );
  assign tick_half = timer == TW'(CPB / 2 - 1);
  assign tick_full = timer == TW'(CPB - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  // start needs a high-to-low transition so a held break line cannot retrigger
  always_comb begin
    next = state;
    done = 1'b0;
    case (state)
      IDLE:   if (!rx_s && rx_prev) next = START;
      START:  if (tick_half) next = sample_bit ? IDLE : DATA;
      DATA:   if (tick_full && bit_idx == IW'(DATA_BITS - 1))
                next = (PARITY == PAR_EVEN || PARITY == PAR_ODD) ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (tick_full) next = STOP;
      STOP:   if (tick_full && stop_idx == 1'(STOP_BITS - 1)) begin
                next = IDLE;
                done = 1'b1;
              end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_prev  <= 1'b1;
      timer    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_prev  <= rx_s;
      timer    <= (next != state || next == IDLE || tick_full) ? '0 : timer + 1'b1;
      bit_idx  <= state != DATA ? '0 : tick_full ? bit_idx + 1'b1 : bit_idx;
      stop_idx <= state != STOP ? 1'b0 : tick_full ? 1'b1 : stop_idx;
      if (state == DATA && tick_full) shreg <= {sample_bit, shreg[DATA_BITS-1:1]};
      if (done) perr <= 1'b0;
      else if (state == uart_pkg::PARITY && tick_full) perr <= ^shreg ^ sample_bit ^ (PARITY == PAR_ODD);
      if (done) ferr <= 1'b0;
      else if (state == STOP && tick_full) ferr <= ferr | ~sample_bit;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      data_out   <= shreg;
      data_valid <= 1'b1;
      parity_err <= perr;
      frame_err  <= ferr | ~sample_bit;
      overrun    <= data_valid & ~data_ready;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench over three receiver configurations (8N1, 7E1, 9O2)
module tb_uart_rx_param;
  localparam int CLK_FREQ = 1000000;
  typedef struct {
    int k;
    logic [8:0] d;
    logic pe;
    logic fe;
    logic ov;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [2:0] ready = 3'b110;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [8:0] d2;
  logic [2:0] valid, perr, ferr, ovr, busy;
  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int nframes = 0;
  always #5 clk = ~clk;
  uart_rx_param u0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .data_out(d0), .data_valid(valid[0]), .data_ready(ready[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0])
  );
  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(62500), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .data_out(d1), .data_valid(valid[1]), .data_ready(ready[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1])
  );
  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(62500), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .data_out(d2), .data_valid(valid[2]), .data_ready(ready[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2])
  );
  function automatic int db_of(input int k);
    return k == 0 ? 8 : k == 1 ? 7 : 9;
  endfunction
  function automatic int par_of(input int k);
    return k;
  endfunction
  function automatic int sb_of(input int k);
    return k == 2 ? 2 : 1;
  endfunction
  function automatic int cpb_of(input int k);
    return CLK_FREQ / (k == 0 ? 9600 : 62500);
  endfunction
  // cycles from the first clock edge seeing the start bit to the completion edge
  function automatic int comp_of(input int k);
    return 2 + cpb_of(k) / 2 + cpb_of(k) * (db_of(k) + (par_of(k) != 0 ? 1 : 0) + sb_of(k));
  endfunction
  function automatic logic [8:0] dout_of(input int k);
    return k == 0 ? {1'b0, d0} : k == 1 ? {2'b0, d1} : d2;
  endfunction
  function automatic logic good_par(input int k, input logic [8:0] d);
    return 1'(($countones(d) + (par_of(k) == 2 ? 1 : 0)) % 2);
  endfunction
  function automatic exp_t model(input int k, input logic [8:0] d, input logic pb, input logic [1:0] st,
                                 input int gb, input logic ov);
    exp_t e;
    logic [8:0] r;
    r = d;
`ifndef UART_RX_MAJORITY_EN
    if (gb >= 1 && gb <= db_of(k)) r[gb-1] = ~r[gb-1];
`endif
    e.k = k;
    e.d = r;
    e.pe = par_of(k) != 0 && pb != good_par(k, r);
    e.fe = !st[0] || (sb_of(k) == 2 && !st[1]);
    e.ov = ov;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input int k, input logic [8:0] d, input logic pb, input logic [1:0] st, input int gb);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < db_of(k); i++) bits.push_back(d[i]);
    if (par_of(k) != 0) bits.push_back(pb);
    for (int s = 0; s < sb_of(k); s++) bits.push_back(st[s]);
    foreach (bits[b])
      for (int c = 0; c < cpb_of(k); c++) begin
        @(negedge clk);
        rx[k] = (b == gb && c == cpb_of(k) / 2) ? ~bits[b] : bits[b];
      end
    @(negedge clk);
    rx[k] = 1'b1;
  endtask
  task automatic frame(input int k, input logic [8:0] d, input logic pb, input logic [1:0] st,
                       input int gb, input logic ov);
    sbq.push_back(model(k, d, pb, st, gb, ov));
    send(k, d, pb, st, gb);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_ready(input int k);
    @(posedge clk);
    #2 ready[k] = 1'b1;
    @(posedge clk);
    #2 ready[k] = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst)
      for (int k = 0; k < 3; k++)
        if (valid[k] && ready[k]) begin
          nframes++;
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL frame u%0d: got unexpected frame d=%0h", k, dout_of(k));
          end else begin
            e = sbq.pop_front();
            if (e.k != k || dout_of(k) != e.d || perr[k] != e.pe || ferr[k] != e.fe || ovr[k] != e.ov) begin
              errors++;
              $display("FAIL frame u%0d: got d=%0h pe=%0b fe=%0b ov=%0b, expected u%0d d=%0h pe=%0b fe=%0b ov=%0b",
                       k, dout_of(k), perr[k], ferr[k], ovr[k], e.k, e.d, e.pe, e.fe, e.ov);
            end
          end
        end
  end
  initial begin
    logic [8:0] d;
    logic pb;
    logic [1:0] st;
    int lat, n0;
    idle(3);
    for (int k = 0; k < 3; k++) begin
      chk("reset data_out", dout_of(k), 0);
      chk("reset flags", {valid[k], perr[k], ferr[k], ovr[k], busy[k]}, 0);
    end
    rst = 1'b1;
    idle(5);
    sbq.push_back(model(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b0));
    lat = 0;
    fork
      send(0, 9'h0A5, 1'b0, 2'b11, -1);
      begin
        @(negedge clk);
        @(posedge clk);
        while (!valid[0] && lat < 3000) begin
          @(posedge clk);
          #1 lat++;
        end
      end
    join
    checks++;
    // nominal 9.5 bit times (988) plus the 2-cycle synchronizer
    if (lat < 986 || lat > 992) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected 986..992", lat);
    end
    chk("held valid", valid[0], 1);
    chk("held data", d0, 8'hA5);
    pulse_ready(0);
    chk("valid after accept", valid[0], 0);
    chk("data after accept", d0, 8'hA5);
    ready[0] = 1'b1;
    frame(1, 9'h035, 1'b1, 2'b11, -1, 1'b0);
    idle(5);
    frame(1, 9'h035, 1'b0, 2'b11, -1, 1'b0);
    idle(5);
    frame(0, 9'h03C, 1'b0, 2'b00, -1, 1'b0);
    idle(5);
    n0 = nframes;
    @(negedge clk);
    rx[0] = 1'b0;
    idle(10);
    chk("glitch busy", busy[0], 1);
    idle(20);
    rx[0] = 1'b1;
    idle(2 * cpb_of(0));
    chk("glitch idle", busy[0], 0);
    chk("glitch no frame", nframes, n0);
    ready[0] = 1'b0;
    sbq.push_back(model(0, 9'h022, 1'b0, 2'b11, -1, 1'b1));
    send(0, 9'h011, 1'b0, 2'b11, -1);
    idle(4);
    send(0, 9'h022, 1'b0, 2'b11, -1);
    idle(4);
    chk("overrun set", ovr[0], 1);
    chk("overrun data", d0, 8'h22);
    pulse_ready(0);
    chk("overrun kept", ovr[0], 1);
    frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b0);
    idle(4);
    sbq.push_back(model(0, 9'h022, 1'b0, 2'b11, -1, 1'b0));
    fork
      send(0, 9'h022, 1'b0, 2'b11, -1);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (comp_of(0) - 1) @(posedge clk);
        #2 ready[0] = 1'b1;
        @(posedge clk);
        #1 chk("accept on completion overrun", ovr[0], 0);
        chk("accept on completion valid", {valid[0], d0}, {1'b1, 8'h22});
        #1 ready[0] = 1'b0;
      end
    join
    pulse_ready(0);
    ready[0] = 1'b1;
    n0 = nframes;
    sbq.push_back(model(0, 9'h000, 1'b0, 2'b00, -1, 1'b0));
    @(negedge clk);
    rx[0] = 1'b0;
    idle(12 * cpb_of(0));
    chk("break one frame", nframes, n0 + 1);
    chk("break waits idle", busy[0], 0);
    rx[0] = 1'b1;
    idle(2 * cpb_of(0));
    chk("break no retrigger", nframes, n0 + 1);
    n0 = nframes;
    frame(2, 9'h1FF, good_par(2, 9'h1FF), 2'b11, -1, 1'b0);
    frame(2, 9'h001, good_par(2, 9'h001), 2'b11, -1, 1'b0);
    idle(5);
    chk("back-to-back frames", nframes, n0 + 2);
    frame(0, 9'h0FF, 1'b0, 2'b11, 1, 1'b0);
    idle(5);
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 6; n++) begin
        d = 9'($urandom) & 9'((1 << db_of(k)) - 1);
        pb = $urandom_range(3) == 0 ? ~good_par(k, d) : good_par(k, d);
        st = {1'($urandom_range(7) != 0), 1'($urandom_range(7) != 0)};
        frame(k, d, pb, st, -1, 1'b0);
        idle($urandom_range(cpb_of(k), 2));
      end
    idle(50);
    n0 = nframes;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      rx[2] = c < 16 ? 1'b0 : c < 32 ? 1'b1 : c < 48 ? 1'b0 : 1'b1;
    end
    chk("busy mid data", busy[2], 1);
    #1 rst = 1'b0;
    #1 chk("reset mid-frame data", d2, 0);
    chk("reset mid-frame flags", {valid[2], perr[2], ferr[2], ovr[2], busy[2]}, 0);
    idle(3);
    rx[2] = 1'b1;
    rst = 1'b1;
    idle(20 * cpb_of(2));
    chk("partial frame dropped", nframes, n0);
    chk("idle after reset", {valid[2], busy[2]}, 0);
    chk("scoreboard drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised next-generation UART receiver. Runs entirely on the system clock; no derived clock.
- Samples each bit at its midpoint using a clocks-per-bit counter.
- Supports 5-9 data bits, none/even/odd parity, and 1 or 2 stop bits.
- Presents each received frame on a valid/ready output register with parity, framing and overrun status. Sits between the pad-side rx line and a byte-consuming host/FIFO.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s. CPB = CLK_FREQ/BAUD_RATE (integer division, 104 at defaults). CPB must be at least 4.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data_out  output  DATA_BITS  received word, LSB = first bit received.
- data_valid  output  1  data_out and the status flags hold an unconsumed frame.
- data_ready  input  1  consumer accepts the frame when data_valid && data_ready.
- parity_err  output  1  parity mismatch for the presented frame; always 0 when PARITY=0.
- frame_err  output  1  at least one stop bit sampled low for the presented frame.
- overrun  output  1  the presented frame overwrote an unconsumed frame.
- busy  output  1  receiver FSM not in IDLE.

Behaviour:
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, FSM=IDLE. Both synchronizer flops reset to 1.
- Input path: rx passes through a 2-flop synchronizer giving rx_s. Edge detection and sampling use rx_s only, so there are 2 cycles of input latency.
- Bit timer: counts 0..CPB-1 and is reloaded at each state entry.
- FSM states:
  - IDLE: rx_s==0 -> START, timer cleared.
  - START: at timer==CPB/2-1, sample rx_s. If 1, this is a false start -> IDLE with no output. If 0 -> DATA, timer cleared, bit index 0.
  - DATA: at timer==CPB-1, shift the sample into the shift register LSB-first and increment the bit index. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
  - PARITY: at timer==CPB-1, sample the parity bit. Even parity: XOR of data and parity bit must be 0. Odd parity: that XOR must be 1. Mismatch -> internal perr=1. Then -> STOP.
  - STOP: at timer==CPB-1, sample. A 0 sets internal ferr. Repeat for STOP_BITS samples. After the last sample, complete the frame -> IDLE. A new start bit is detectable from the next cycle (mid-stop-bit).
- Frame completion, in the same cycle as the last stop sample: data_out<=shift register, parity_err<=perr, frame_err<=ferr, data_valid<=1, and perr/ferr are cleared.
- Handshake:
  - When data_valid && data_ready and no completion occurs that cycle, data_valid falls next cycle. The flags are left unchanged.
  - Completion while data_valid=1 and data_ready=0: the new frame overwrites and overrun<=1.
  - Completion with data_valid && data_ready in the same cycle: the old frame is consumed, the new frame is loaded, and overrun<=0.
  - overrun is otherwise updated only on completion, to 0 when no unconsumed frame existed.
- A break (line held low) produces a frame with data 0 and frame_err=1. After it, the FSM waits in IDLE for rx_s high-then-low; it does not retrigger on a continuous low.
- Reset asserted mid-frame: immediate return to the reset values. A partial frame is discarded.
- busy=1 in START, DATA, PARITY and STOP.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each data, parity and stop sample is the 2-of-3 majority of rx_s at timer==CPB/2-2, CPB/2-1 and CPB/2 of that bit. The start-bit check also uses the majority of three samples.
- Undefined: a single sample is taken at timer==CPB/2-1 of each bit.
- Bit timing, latency and all other behaviour are identical either way.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - Parity-mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - A function computing CPB from CLK_FREQ and BAUD_RATE.
- One natural sub-module, uart_rx_sync. It contains the 2-flop synchronizer plus the optional majority filter, outputs rx_s and sample_bit, and is reusable by a future uart_tx loopback checker.

Test Plan:
- 8N1 defaults: send 0xA5 -> data_out=0xA5, data_valid=1, parity_err=0, frame_err=0, valid asserted about 9.5 bit times after the start edge (±2 clk). Assert data_ready for 1 cycle -> data_valid=0.
- PARITY=1, DATA_BITS=7: send 0x35 with parity bit 1 -> parity_err=1. Resend with correct parity bit 0 -> parity_err=0.
- Stop bit driven low on 0x3C -> frame_err=1, data_out=0x3C. A 30-cycle low glitch on the idle line -> no data_valid, FSM back in IDLE.
- Overrun: send 0x11 then 0x22 with data_ready=0 -> data_out=0x22, overrun=1. Repeat with data_ready=1 during the second completion cycle -> overrun=0.
- STOP_BITS=2, DATA_BITS=9: send 0x1FF then 0x001 back-to-back -> two frames, no errors. Drop rst mid-DATA of a third frame -> all outputs 0, no frame produced.
- With UART_RX_MAJORITY_EN: a 1-cycle low glitch at mid-bit on a '1' data bit of 0xFF -> data_out=0xFF. Without the macro -> data_out=0xFE when the glitch is on bit 0.
